// File: rtl/encoders_panel.sv
// Front-panel scanner: walks one analog MUX over encoder A/B/button and plain-button inputs,
// debounces every input, decodes x1 quadrature, tracks hold durations and raises a sticky change IRQ.
module encoders_panel #(
    parameter int CLK_DIV_BITS  = 7,
    parameter int MUX_ADDR_BITS = 4,
    parameter int DEBOUNCE_BITS = 10,
    parameter int TICK_DIV_BITS = 10,
    parameter int ENCODER_COUNT = 5,
    parameter int BUTTON_COUNT  = 1,
    parameter int POS_BITS      = 4,
    parameter int DUR_BITS      = 7
) (
    input  logic                     CLK,
    input  logic                     RESET,
    output logic [MUX_ADDR_BITS-1:0] MUX_ADDR,
    input  logic                     MUX_OUT,
    input  logic [7:0]               RD_ADDR,
    output logic [31:0]              RD_DATA,
    output logic                     IRQ,
    input  logic                     IRQ_ACK
);
    localparam int INPUT_COUNT = 3 * ENCODER_COUNT + BUTTON_COUNT;
    localparam int DUR_COUNT   = ENCODER_COUNT + BUTTON_COUNT;
    localparam int STATUS_ADDR = ENCODER_COUNT + BUTTON_COUNT;
    localparam int PRESS_BIT   = 2 * POS_BITS + DUR_BITS;

    logic [CLK_DIV_BITS-1:0]  dwell;
    logic [TICK_DIV_BITS-1:0] frame_cnt;
    logic [INPUT_COUNT-1:0]   db_val;
    logic [DEBOUNCE_BITS-1:0] db_cnt    [INPUT_COUNT];
    logic [POS_BITS-1:0]      pos_norm  [ENCODER_COUNT];
    logic [POS_BITS-1:0]      pos_press [ENCODER_COUNT];
    logic [DUR_BITS-1:0]      dur       [DUR_COUNT];
    logic [7:0]               last_cnt;
    logic                     pending;

    logic                     sample_en;
    logic                     frame_end;
    logic                     tick;
    logic [INPUT_COUNT-1:0]   flip;
    logic [ENCODER_COUNT-1:0] a_rise;
    logic [DUR_COUNT-1:0]     btn_flip;
    logic                     change_any;
    logic [31:0]              rd_next;

    // A flip is the sample that completes a debounce run on the currently selected input.
    always_comb begin
        flip       = '0;
        a_rise     = '0;
        btn_flip   = '0;
        sample_en  = &dwell;
        frame_end  = sample_en && (&MUX_ADDR);
        tick       = frame_end && (&frame_cnt);
        for (int i = 0; i < INPUT_COUNT; i++) begin
            flip[i] = sample_en && (MUX_ADDR == MUX_ADDR_BITS'(i))
                   && (MUX_OUT != db_val[i]) && (&db_cnt[i]);
        end
        for (int e = 0; e < ENCODER_COUNT; e++) begin
            a_rise[e]   = flip[3*e] && MUX_OUT;
            btn_flip[e] = flip[3*e+2];
        end
        for (int j = 0; j < BUTTON_COUNT; j++) begin
            btn_flip[ENCODER_COUNT+j] = flip[3*ENCODER_COUNT+j];
        end
        change_any = (|a_rise) || (|btn_flip);
    end

    always_comb begin
        rd_next = '0;
        for (int e = 0; e < ENCODER_COUNT; e++) begin
            if (RD_ADDR == 8'(e)) begin
                rd_next[POS_BITS-1:0]           = pos_norm[e];
                rd_next[2*POS_BITS-1:POS_BITS]  = pos_press[e];
                rd_next[2*POS_BITS +: DUR_BITS] = dur[e];
                rd_next[PRESS_BIT]              = ~db_val[3*e+2];
            end
        end
        for (int j = 0; j < BUTTON_COUNT; j++) begin
            if (RD_ADDR == 8'(ENCODER_COUNT + j)) begin
                rd_next[DUR_BITS-1:0] = dur[ENCODER_COUNT+j];
                rd_next[DUR_BITS]     = ~db_val[3*ENCODER_COUNT+j];
            end
        end
        if (RD_ADDR == 8'(STATUS_ADDR)) begin
            rd_next[7:0] = last_cnt;
            rd_next[8]   = IRQ;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            dwell     <= '0;
            MUX_ADDR  <= '0;
            frame_cnt <= '0;
            db_val    <= '1;
            for (int i = 0; i < INPUT_COUNT; i++) begin
                db_cnt[i] <= '0;
            end
            for (int e = 0; e < ENCODER_COUNT; e++) begin
                pos_norm[e]  <= '0;
                pos_press[e] <= '0;
            end
            for (int k = 0; k < DUR_COUNT; k++) begin
                dur[k] <= '0;
            end
            last_cnt <= '0;
            pending  <= 1'b0;
            IRQ      <= 1'b0;
            RD_DATA  <= '0;
        end else begin
            dwell <= dwell + 1'b1;
            if (sample_en) begin
                MUX_ADDR <= MUX_ADDR + 1'b1;
            end
            if (frame_end) begin
                frame_cnt <= frame_cnt + 1'b1;
            end

            for (int i = 0; i < INPUT_COUNT; i++) begin
                if (sample_en && (MUX_ADDR == MUX_ADDR_BITS'(i))) begin
                    if (MUX_OUT == db_val[i]) begin
                        db_cnt[i] <= '0;
                    end else if (&db_cnt[i]) begin
                        db_val[i] <= MUX_OUT;
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 1'b1;
                    end
                end
            end

            // B high at the A rising edge means counter-clockwise.
            for (int e = 0; e < ENCODER_COUNT; e++) begin
                if (a_rise[e]) begin
                    if (!db_val[3*e+2]) begin
                        if (db_val[3*e+1]) pos_press[e] <= pos_press[e] - 1'b1;
                        else               pos_press[e] <= pos_press[e] + 1'b1;
                    end else begin
                        if (db_val[3*e+1]) pos_norm[e] <= pos_norm[e] - 1'b1;
                        else               pos_norm[e] <= pos_norm[e] + 1'b1;
                    end
                end
            end

            for (int k = 0; k < DUR_COUNT; k++) begin
                if (btn_flip[k]) begin
                    dur[k] <= '0;
                end else if (tick && !(&dur[k])) begin
                    dur[k] <= dur[k] + 1'b1;
                end
            end

            // A change landing on the tick cycle is folded into that tick.
            if (tick) begin
                if (pending || change_any) begin
                    last_cnt <= '0;
                end else if (last_cnt != 8'hFF) begin
                    last_cnt <= last_cnt + 1'b1;
                end
                pending <= 1'b0;
            end else if (change_any) begin
                pending <= 1'b1;
            end

            if (change_any) begin
                IRQ <= 1'b1;
            end else if (IRQ_ACK) begin
                IRQ <= 1'b0;
            end

            RD_DATA <= rd_next;
        end
    end
endmodule

// File: tb/tb_encoders_panel.sv
// Directed bench for encoders_panel with a fast scan: 4-clock dwell, 64-clock frame, 256-clock tick.
module tb_encoders_panel;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  mux_addr;
    logic        mux_out;
    logic [7:0]  rd_addr;
    logic [31:0] rd_data;
    logic        irq;
    logic        irq_ack;
    logic [15:0] level;
    int          cyc;
    int          n_checks;
    int          n_pass;

    encoders_panel #(
        .CLK_DIV_BITS(2),
        .DEBOUNCE_BITS(2),
        .TICK_DIV_BITS(2)
    ) dut (
        .CLK(clk),
        .RESET(rst),
        .MUX_ADDR(mux_addr),
        .MUX_OUT(mux_out),
        .RD_ADDR(rd_addr),
        .RD_DATA(rd_data),
        .IRQ(irq),
        .IRQ_ACK(irq_ack)
    );

    always #5 clk = ~clk;

    // External analog MUX: each input's level is held in the panel vector.
    assign mux_out = level[mux_addr];

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        cyc += n;
    endtask

    task automatic wait_until(input int k);
        while (cyc < k) step(1);
    endtask

    // One reset edge; cyc 0 is the negedge right after release.
    task automatic apply_reset();
        rst     = 1'b1;
        level   = '1;
        irq_ack = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        level   = '1;
        irq_ack = 1'b0;
        rd_addr = 8'd6;
        repeat (2) @(negedge clk);
        n_checks++;
        if (mux_addr !== 4'd0) $display("FAIL reset_mux_addr got=%0d exp=0", mux_addr);
        else n_pass++;
        n_checks++;
        if (irq !== 1'b0) $display("FAIL reset_irq got=%0b exp=0", irq);
        else n_pass++;
        n_checks++;
        if (rd_data !== 32'd0) $display("FAIL reset_rd_data got=%h exp=0", rd_data);
        else n_pass++;
    endtask

    task automatic test_scan();
        logic [3:0]  exp_addr;
        logic [31:0] exp_stat;
        rd_addr = 8'd6;
        apply_reset();
        for (int k = 0; k < 780; k++) begin
            exp_addr = 4'((k / 4) % 16);
            exp_stat = (k == 0) ? 32'd0 : 32'((k - 1) / 256);
            n_checks++;
            if (mux_addr !== exp_addr) $display("FAIL scan_addr cyc=%0d got=%0d exp=%0d", cyc, mux_addr, exp_addr);
            else n_pass++;
            n_checks++;
            if (irq !== 1'b0) $display("FAIL scan_irq cyc=%0d got=%0b exp=0", cyc, irq);
            else n_pass++;
            n_checks++;
            if (rd_data !== exp_stat) $display("FAIL scan_status cyc=%0d got=%h exp=%h", cyc, rd_data, exp_stat);
            else n_pass++;
            step(1);
        end
    endtask

    task automatic test_glitch();
        rd_addr = 8'd0;
        apply_reset();
        level[2] = 1'b0;
        wait_until(100);
        level[2] = 1'b1;
        wait_until(250);
        n_checks++;
        if (rd_data !== 32'd0) $display("FAIL glitch_enc0 got=%h exp=00000000", rd_data);
        else n_pass++;
        n_checks++;
        if (irq !== 1'b0) $display("FAIL glitch_irq got=%0b exp=0", irq);
        else n_pass++;
    endtask

    task automatic test_press();
        rd_addr = 8'd0;
        apply_reset();
        level[2] = 1'b0;
        wait_until(203);
        n_checks++;
        if (rd_data !== 32'd0) $display("FAIL press_before got=%h exp=00000000", rd_data);
        else n_pass++;
        n_checks++;
        if (irq !== 1'b0) $display("FAIL press_irq_before got=%0b exp=0", irq);
        else n_pass++;
        wait_until(205);
        n_checks++;
        if (rd_data !== 32'h8000) $display("FAIL press_enc0 got=%h exp=00008000", rd_data);
        else n_pass++;
        n_checks++;
        if (irq !== 1'b1) $display("FAIL press_irq got=%0b exp=1", irq);
        else n_pass++;
        wait_until(258);
        n_checks++;
        if (rd_data !== 32'h8100) $display("FAIL press_dur_tick got=%h exp=00008100", rd_data);
        else n_pass++;
    endtask

    task automatic test_irq_race();
        apply_reset();
        level[2] = 1'b0;
        wait_until(203);
        n_checks++;
        if (irq !== 1'b0) $display("FAIL race_irq_pre got=%0b exp=0", irq);
        else n_pass++;
        irq_ack = 1'b1;
        step(1);
        n_checks++;
        if (irq !== 1'b1) $display("FAIL race_set_and_ack got=%0b exp=1", irq);
        else n_pass++;
        step(1);
        irq_ack = 1'b0;
        n_checks++;
        if (irq !== 1'b0) $display("FAIL race_lone_ack got=%0b exp=0", irq);
        else n_pass++;
        wait_until(210);
        n_checks++;
        if (irq !== 1'b0) $display("FAIL race_stays_clear got=%0b exp=0", irq);
        else n_pass++;
    endtask

    task automatic test_rotation();
        rd_addr = 8'd1;
        apply_reset();
        for (int r = 0; r < 3; r++) begin
            wait_until(512 * r);
            level[3] = 1'b0;
            wait_until(512 * r + 256);
            level[3] = 1'b1;
        end
        wait_until(1500);
        n_checks++;
        if (rd_data !== 32'h050D) $display("FAIL rot_ccw got=%h exp=0000050d", rd_data);
        else n_pass++;
        wait_until(1536);
        level[3] = 1'b0;
        level[4] = 1'b0;
        level[5] = 1'b0;
        wait_until(1792);
        level[3] = 1'b1;
        wait_until(2010);
        n_checks++;
        if (rd_data !== 32'h811D) $display("FAIL rot_pressed got=%h exp=0000811d", rd_data);
        else n_pass++;
    endtask

    task automatic test_wrap();
        rd_addr = 8'd2;
        apply_reset();
        level[7] = 1'b0;
        for (int r = 0; r < 17; r++) begin
            wait_until(512 * r);
            level[6] = 1'b0;
            if (r == 16) begin
                wait_until(8202);
                n_checks++;
                if (rd_data !== 32'h2000) $display("FAIL wrap_16 got=%h exp=00002000", rd_data);
                else n_pass++;
            end
            wait_until(512 * r + 256);
            level[6] = 1'b1;
        end
        wait_until(8714);
        n_checks++;
        if (rd_data !== 32'h2201) $display("FAIL wrap_17 got=%h exp=00002201", rd_data);
        else n_pass++;
    endtask

    task automatic test_saturation();
        rd_addr = 8'd5;
        apply_reset();
        level[15] = 1'b0;
        wait_until(260);
        n_checks++;
        if (rd_data !== 32'h80) $display("FAIL sat_change_on_tick got=%h exp=00000080", rd_data);
        else n_pass++;
        rd_addr = 8'd6;
        wait_until(262);
        n_checks++;
        if (rd_data !== 32'h100) $display("FAIL sat_last_pending got=%h exp=00000100", rd_data);
        else n_pass++;
        wait_until(514);
        n_checks++;
        if (rd_data !== 32'h101) $display("FAIL sat_last_incr got=%h exp=00000101", rd_data);
        else n_pass++;
        rd_addr = 8'd5;
        wait_until(256 * 127 + 4);
        n_checks++;
        if (rd_data !== 32'hFE) $display("FAIL sat_126 got=%h exp=000000fe", rd_data);
        else n_pass++;
        wait_until(256 * 128 + 4);
        n_checks++;
        if (rd_data !== 32'hFF) $display("FAIL sat_127 got=%h exp=000000ff", rd_data);
        else n_pass++;
        wait_until(256 * 201 + 10);
        n_checks++;
        if (rd_data !== 32'hFF) $display("FAIL sat_200 got=%h exp=000000ff", rd_data);
        else n_pass++;
        rd_addr = 8'd6;
        wait_until(256 * 201 + 12);
        n_checks++;
        if (rd_data !== 32'h1C8) $display("FAIL sat_last_200 got=%h exp=000001c8", rd_data);
        else n_pass++;
    endtask

    task automatic test_reset_mid_op();
        logic [7:0] addrs [9];
        addrs = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd200};
        rd_addr = 8'd0;
        apply_reset();
        level[0] = 1'b0;
        level[2] = 1'b0;
        wait_until(256);
        level[0] = 1'b1;
        wait_until(384);
        level[5] = 1'b0;
        wait_until(480);
        n_checks++;
        if (rd_data !== 32'h81F0) $display("FAIL midrst_pre got=%h exp=000081f0", rd_data);
        else n_pass++;
        wait_until(482);
        rst      = 1'b1;
        level[2] = 1'b1;
        rd_addr  = 8'd1;
        @(negedge clk);
        n_checks++;
        if (mux_addr !== 4'd0) $display("FAIL midrst_mux_addr got=%0d exp=0", mux_addr);
        else n_pass++;
        n_checks++;
        if (irq !== 1'b0) $display("FAIL midrst_irq got=%0b exp=0", irq);
        else n_pass++;
        n_checks++;
        if (rd_data !== 32'd0) $display("FAIL midrst_rd_data got=%h exp=0", rd_data);
        else n_pass++;
        rst = 1'b0;
        cyc = 0;
        for (int a = 0; a < 9; a++) begin
            rd_addr = addrs[a];
            step(1);
            n_checks++;
            if (rd_data !== 32'd0) $display("FAIL midrst_read addr=%0d got=%h exp=0", addrs[a], rd_data);
            else n_pass++;
        end
        while (cyc < 216) begin
            n_checks++;
            if (irq !== 1'b0) $display("FAIL midrst_quiet cyc=%0d got=%0b exp=0", cyc, irq);
            else n_pass++;
            step(1);
        end
        rd_addr = 8'd1;
        step(1);
        n_checks++;
        if (irq !== 1'b1) $display("FAIL midrst_late_irq got=%0b exp=1", irq);
        else n_pass++;
        n_checks++;
        if (rd_data !== 32'h8000) $display("FAIL midrst_late_enc1 got=%h exp=00008000", rd_data);
        else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        cyc      = 0;
        test_reset();
        test_scan();
        test_glitch();
        test_press();
        test_irq_race();
        test_rotation();
        test_wrap();
        test_saturation();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached at cyc=%0d", cyc);
        $fatal(1, "time limit");
    end
endmodule
